mem_stage: RTL

// - MEM stage of the five-stage pipeline. Sits between the EX/MEM register and dmemory.
// - Drives dmemory address/read_write/access_size/data_in and checks load/store alignment.
// - Owns the MEM/WB pipeline register.
// - Byte/half-selects and sign/zero-extends dmemory data_out into the writeback value.

---
 rtl/mem_stage_if.sv | 52 +++++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles the buses around the MEM stage: the EX/MEM inputs, the dmemory
// request/response pair and the MEM/WB outputs.
//   ex_*        : instruction arriving from the EX/MEM register
//   dmem_*      : dmemory address, read/write, size, store data, read data
//   wb_*        : MEM/WB register contents presented to writeback
// Modports:
//   slave  : the MEM stage itself
//   master : whoever drives EX/MEM and dmemory read data (pipeline or bench)
// -----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    logic                 ex_valid;
    logic [XLEN-1:0]      ex_alu_result;
    logic [XLEN-1:0]      ex_rs2_data;
    logic [2:0]           ex_funct3;
    logic                 ex_mem_read;
    logic                 ex_mem_write;
    logic                 ex_reg_write;
    logic [REG_IDX_W-1:0] ex_rd;

    logic [XLEN-1:0]      dmem_address;
    logic                 dmem_read_write;
    logic [1:0]           dmem_access_size;
    logic [XLEN-1:0]      dmem_data_in;
    logic [XLEN-1:0]      dmem_data_out;

    logic                 wb_valid;
    logic                 wb_reg_write;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 wb_misaligned;

    modport slave (
        input  ex_valid, ex_alu_result, ex_rs2_data, ex_funct3,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_rd,
               dmem_data_out,
        output dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
               wb_valid, wb_reg_write, wb_rd, wb_data, wb_misaligned
    );

    modport master (
        output ex_valid, ex_alu_result, ex_rs2_data, ex_funct3,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_rd,
               dmem_data_out,
        input  dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
               wb_valid, wb_reg_write, wb_rd, wb_data, wb_misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the five-stage pipeline. Drives dmemory from the EX/MEM
// instruction, flags misaligned half/word accesses, owns the MEM/WB register
// and lane-selects / extends dmemory read data into the writeback value.
// A small LIVE/HELD FSM captures load data when MEM/WB is stalled, because
// dmemory keeps returning data for whatever address EX/MEM presents.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; wins over stall and flush
//   stall  : hold MEM/WB and held load data; suppress dmemory writes
//   flush  : squash the instruction entering MEM/WB (ignored while stalled)
//   bus    : mem_stage_if.slave carrying the ex_*, dmem_* and wb_* signals
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    mem_stage_if.slave     bus
);

    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        LIVE,
        HELD
    } hold_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu_result;
        logic [2:0]           funct3;
        logic [1:0]           off;
        logic                 is_load;
        logic                 misaligned;
    } mem_wb_t;

    mem_wb_t     wb_q, wb_d;
    hold_state_e state_q, state_d;
    logic [XLEN-1:0] held_q, held_d;

    logic [1:0]      size;
    logic            misalign;
    logic            ex_live;
    logic [XLEN-1:0] extracted;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;

    // ------------------------------------------------------------------
    // Request path: combinational straight from EX/MEM
    // ------------------------------------------------------------------
    assign size     = bus.ex_funct3[1:0];
    assign misalign = (bus.ex_mem_read | bus.ex_mem_write) &
                      (((size == SIZE_HALF) & bus.ex_alu_result[0]) |
                       ((size == SIZE_WORD) & (bus.ex_alu_result[1:0] != 2'b00)));
    assign ex_live  = bus.ex_valid & ~flush;

    assign bus.dmem_address     = bus.ex_alu_result;
    assign bus.dmem_access_size = size;
    assign bus.dmem_data_in     = bus.ex_rs2_data;
    // A write must not fire for a squashed, stalled, reset or misaligned store.
    assign bus.dmem_read_write  = bus.ex_valid & bus.ex_mem_write & ~misalign &
                                  ~stall & ~flush & ~reset;

    // ------------------------------------------------------------------
    // MEM/WB register next state
    // ------------------------------------------------------------------
    // NOTE: every always_comb output takes a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        wb_d = wb_q;
        if (!stall) begin
            wb_d.valid      = ex_live;
            wb_d.reg_write  = bus.ex_reg_write & ~misalign & ex_live;
            wb_d.rd         = bus.ex_rd;
            wb_d.alu_result = bus.ex_alu_result;
            wb_d.funct3     = bus.ex_funct3;
            wb_d.off        = bus.ex_alu_result[1:0];
            wb_d.is_load    = bus.ex_mem_read;
            wb_d.misaligned = misalign & ex_live;
        end
    end

    // ------------------------------------------------------------------
    // Load extract from the live dmemory word
    // ------------------------------------------------------------------
    always_comb begin
        lane_byte = 8'd0;
        lane_half = 16'd0;
        case (wb_q.off)
            2'd0:    lane_byte = bus.dmem_data_out[7:0];
            2'd1:    lane_byte = bus.dmem_data_out[15:8];
            2'd2:    lane_byte = bus.dmem_data_out[23:16];
            default: lane_byte = bus.dmem_data_out[31:24];
        endcase
        lane_half = wb_q.off[1] ? bus.dmem_data_out[31:16] : bus.dmem_data_out[15:0];

        case (wb_q.funct3)
            3'b000:  extracted = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            3'b001:  extracted = {{(XLEN-16){lane_half[15]}}, lane_half};
            3'b100:  extracted = {{(XLEN-8){1'b0}}, lane_byte};
            3'b101:  extracted = {{(XLEN-16){1'b0}}, lane_half};
            default: extracted = bus.dmem_data_out;
        endcase
    end

    // ------------------------------------------------------------------
    // Held-load FSM: freeze the extracted value on the first stalled cycle
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        case (state_q)
            LIVE: begin
                if (stall && wb_q.valid && wb_q.is_load) begin
                    state_d = HELD;
                    held_d  = extracted;
                end
            end
            HELD: begin
                if (!stall) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q    <= '0;
            state_q <= LIVE;
            held_q  <= '0;
        end else begin
            wb_q    <= wb_d;
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // ------------------------------------------------------------------
    // Writeback outputs
    // ------------------------------------------------------------------
    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_reg_write  = wb_q.reg_write;
    assign bus.wb_rd         = wb_q.rd;
    assign bus.wb_misaligned = wb_q.misaligned;
    assign bus.wb_data       = !wb_q.is_load  ? wb_q.alu_result :
                               (state_q == HELD) ? held_q : extracted;

endmodule
